// File: rtl/main_memory_responder_pkg.sv
// Shared types for the cache<->memory line interface: opcodes, channel bundles and responder states.
package main_memory_responder_pkg;

  localparam int MEM_ADDR_WIDTH = 32;
  localparam int MEM_LINE_WIDTH = 128;

  localparam logic MEM_OPREAD  = 1'b0;
  localparam logic MEM_OPWRITE = 1'b1;

  typedef struct packed {
    logic                      op;
    logic [MEM_ADDR_WIDTH-1:0] address;
    logic [MEM_LINE_WIDTH-1:0] data;
    logic                      valid;
    logic                      ready;
  } type_cache2memory_s;

  typedef struct packed {
    logic [MEM_LINE_WIDTH-1:0] data;
    logic                      valid;
    logic                      ready;
  } type_memory2cache_s;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_RESP = 2'd2
  } type_mem_state_e;

endpackage

// File: rtl/main_memory_responder.sv
// Line-granular memory responder: one request at a time, fixed latency, then a held response.
module main_memory_responder
  import main_memory_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WIDTH  = 128,
  parameter int DEPTH_LINES = 256,
  parameter int LATENCY     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_op_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [LINE_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [LINE_WIDTH-1:0] rsp_rdata_o
);

  localparam int OFF   = $clog2(LINE_WIDTH / 8);
  localparam int IDX   = $clog2(DEPTH_LINES);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  type_mem_state_e       state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  op_r;
  logic [IDX-1:0]        idx_r;
  logic [LINE_WIDTH-1:0] wdata_r;
  logic [LINE_WIDTH-1:0] rdata_r;
  logic                  req_ready_r;
  logic                  rsp_valid_r;
  logic [LINE_WIDTH-1:0] mem_r [DEPTH_LINES];

  logic                  accept_s;
  logic                  commit_s;
  logic [ADDR_WIDTH-1:0] unused_addr_s;

  // req_ready_r is only ever high in IDLE, so it doubles as the state qualifier
  assign accept_s      = req_valid_i && req_ready_r;
  assign commit_s      = (state_r == MEM_WAIT) && (cnt_r == {CNT_W{1'b0}});
  assign unused_addr_s = req_addr_i;

  assign req_ready_o = req_ready_r;
  assign rsp_valid_o = rsp_valid_r;
  assign rsp_rdata_o = rdata_r;

  // Request/response sequencing, latency countdown and registered channel outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= MEM_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      op_r        <= MEM_OPREAD;
      idx_r       <= {IDX{1'b0}};
      wdata_r     <= {LINE_WIDTH{1'b0}};
      rdata_r     <= {LINE_WIDTH{1'b0}};
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
    end else begin
      case (state_r)
        MEM_IDLE: begin
          if (accept_s) begin
            op_r        <= req_op_i;
            idx_r       <= req_addr_i[OFF +: IDX];
            wdata_r     <= req_wdata_i;
            cnt_r       <= CNT_W'(LATENCY - 1);
            req_ready_r <= 1'b0;
            state_r     <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          // The commit edge lands exactly LATENCY edges after the accept edge
          if (commit_s) begin
            state_r     <= MEM_RESP;
            rsp_valid_r <= 1'b1;
            rdata_r     <= (op_r == MEM_OPWRITE) ? {LINE_WIDTH{1'b0}} : mem_r[idx_r];
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        MEM_RESP: begin
          if (rsp_ready_i) begin
            state_r     <= MEM_IDLE;
            rsp_valid_r <= 1'b0;
            rdata_r     <= {LINE_WIDTH{1'b0}};
            req_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= MEM_IDLE;
          rsp_valid_r <= 1'b0;
          rdata_r     <= {LINE_WIDTH{1'b0}};
          req_ready_r <= 1'b1;
        end
      endcase
    end
  end

  // Backing store; deliberately unreset so contents survive a reset
  always_ff @(posedge clk) begin
    if (commit_s && (op_r == MEM_OPWRITE)) begin
      mem_r[idx_r] <= wdata_r;
    end
  end

endmodule

// File: tb/tb_main_memory_responder.sv
// Self-checking bench for main_memory_responder: vector table, reset/backpressure/back-to-back sequences,
// randomized traffic against a line-array model, and a LATENCY=1 instance.
module tb_main_memory_responder;

  localparam int LAT = 4;
  localparam logic [127:0] DEAD = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
  localparam logic [127:0] A5   = 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5;
  localparam logic [127:0] OLD3 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         req_valid, req_ready, req_op, rsp_valid, rsp_ready;
  logic [31:0]  req_addr;
  logic [127:0] req_wdata, rsp_rdata;

  logic         b_req_valid, b_req_ready, b_req_op, b_rsp_valid, b_rsp_ready;
  logic [31:0]  b_req_addr;
  logic [127:0] b_req_wdata, b_rsp_rdata;

  main_memory_responder #(.ADDR_WIDTH(32), .LINE_WIDTH(128), .DEPTH_LINES(256), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata)
  );

  main_memory_responder #(.ADDR_WIDTH(32), .LINE_WIDTH(128), .DEPTH_LINES(256), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_op_i(b_req_op),
    .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_rdata_o(b_rsp_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [127:0] model_mem [256];
  bit           model_known [256];

  typedef struct {
    bit           op;
    logic [31:0]  addr;
    logic [127:0] wdata;
    int           hold;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl [8];

  function automatic void check(string name, logic [127:0] got, logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endfunction

  function automatic void check_i(string name, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_apply(input bit op, input logic [31:0] addr, input logic [127:0] wd,
                             output logic [127:0] exp, output bit known);
    int idx;
    idx = int'((addr / 32'd16) % 32'd256);
    if (op) begin
      model_mem[idx]   = wd;
      model_known[idx] = 1'b1;
      exp   = '0;
      known = 1'b1;
    end else begin
      exp   = model_mem[idx];
      known = model_known[idx];
    end
  endtask

  task automatic do_txn(input bit op, input logic [31:0] addr, input logic [127:0] wd, input int hold,
                        output logic [127:0] rd, output int lat);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    if (!req_ready) check_i("accept_timeout", 0, 1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    rsp_ready = (hold == 0);
    tick();
    req_valid = 1'b0; req_op = ~op; req_addr = $urandom; req_wdata = {4{$urandom}};
    n = 0;
    while (!rsp_valid && n < 50) begin
      check_i("wait_ready_low", int'(req_ready), 0);
      tick();
      n++;
    end
    lat = n;
    check_i("resp_ready_low", int'(req_ready), 0);
    rd = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      tick();
      check_i("hold_valid", int'(rsp_valid), 1);
      check("hold_data", rsp_rdata, rd);
      check_i("hold_req_ready", int'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    tick();
    check_i("post_valid", int'(rsp_valid), 0);
    check("post_data", rsp_rdata, '0);
    check_i("post_req_ready", int'(req_ready), 1);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] rd, exp;
    logic [127:0] b2b_exp [3];
    logic [31:0]  b2b_addr [3];
    int lat, acc, resp;
    bit known, op, acc_now, hs_now;

    for (int i = 0; i < 256; i++) begin model_mem[i] = '0; model_known[i] = 1'b0; end
    reset = 1'b1;
    req_valid = 1'b0; req_op = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_op = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 1'b0;
    tick(); tick();
    check_i("rst_req_ready", int'(req_ready), 1);
    check_i("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_rdata", rsp_rdata, '0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_i("idle_no_rsp", int'(rsp_valid), 0);
    end

    // Reset in the middle of a write's wait: the write must never land
    do_txn(1'b1, 32'h0000_0030, OLD3, 0, rd, lat);
    model_apply(1'b1, 32'h0000_0030, OLD3, exp, known);
    req_valid = 1'b1; req_op = 1'b1; req_addr = 32'h0000_0030; req_wdata = A5;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;
    #1;
    check_i("abort_valid_now", int'(rsp_valid), 0);
    tick();
    reset = 1'b0;
    tick();
    check_i("abort_req_ready", int'(req_ready), 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_i("abort_no_rsp", int'(rsp_valid), 0);
    end
    do_txn(1'b0, 32'h0000_0030, '0, 0, rd, lat);
    check("abort_old_data", rd, OLD3);
    check_i("abort_not_a5", int'(rd == A5), 0);

    tbl[0] = '{1'b1, 32'h0000_0010, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 0, 128'h0};
    tbl[1] = '{1'b0, 32'h0000_0010, 128'h0, 0, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677};
    tbl[2] = '{1'b1, 32'h0000_1010, DEAD, 1, 128'h0};
    tbl[3] = '{1'b0, 32'h0000_0010, 128'h0, 2, DEAD};
    tbl[4] = '{1'b0, 32'h0000_1010, 128'h0, 0, DEAD};
    tbl[5] = '{1'b1, 32'h0000_ABCF, 128'hC0FF_EE00_C0FF_EE01_C0FF_EE02_C0FF_EE03, 0, 128'h0};
    tbl[6] = '{1'b0, 32'h0000_0BC0, 128'h0, 0, 128'hC0FF_EE00_C0FF_EE01_C0FF_EE02_C0FF_EE03};
    tbl[7] = '{1'b0, 32'hFFFF_F01C, 128'h0, 10, DEAD};
    for (int i = 0; i < 8; i++) begin
      do_txn(tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].hold, rd, lat);
      model_apply(tbl[i].op, tbl[i].addr, tbl[i].wdata, exp, known);
      check_i($sformatf("vec%0d_latency", i), lat, LAT);
      check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp);
    end

    // Randomized traffic over a small window of lines so reads hit earlier writes
    for (int i = 0; i < 40; i++) begin
      logic [31:0]  addr;
      logic [127:0] wd;
      int hold;
      op   = ($urandom_range(0, 1) == 1);
      addr = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(64, 79)) << 4) | 32'($urandom_range(0, 15));
      wd   = {4{$urandom}};
      hold = $urandom_range(0, 3);
      model_apply(op, addr, wd, exp, known);
      do_txn(op, addr, wd, hold, rd, lat);
      check_i("rand_latency", lat, LAT);
      if (op || known) check("rand_rdata", rd, exp);
    end

    // Back-to-back reads with req_valid held high
    for (int i = 0; i < 3; i++) begin
      b2b_addr[i] = 32'h0000_0500 + 32'(i * 16);
      b2b_exp[i]  = {4{32'hB2B0_0000 + 32'(i)}};
      do_txn(1'b1, b2b_addr[i], b2b_exp[i], 0, rd, lat);
      model_apply(1'b1, b2b_addr[i], b2b_exp[i], exp, known);
    end
    acc = 0; resp = 0;
    req_valid = 1'b1; req_op = 1'b0; req_addr = b2b_addr[0]; rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && resp < 3; cyc++) begin
      acc_now = req_valid && req_ready;
      hs_now  = rsp_valid && rsp_ready;
      if (hs_now) begin
        check($sformatf("b2b_data%0d", resp), rsp_rdata, b2b_exp[resp]);
        check_i("b2b_no_accept_in_hs", int'(req_ready), 0);
        resp++;
      end
      tick();
      if (acc_now) begin
        acc++;
        if (acc < 3) req_addr = b2b_addr[acc];
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0; rsp_ready = 1'b0;
    check_i("b2b_accepts", acc, 3);
    check_i("b2b_responses", resp, 3);

    // LATENCY=1 instance: write then read line 7
    for (int i = 0; i < 2; i++) begin
      check_i("l1_ready", int'(b_req_ready), 1);
      b_req_valid = 1'b1; b_req_op = (i == 0); b_req_addr = 32'h0000_0070;
      b_req_wdata = 128'h7777_0000_7777_1111_7777_2222_7777_3333;
      b_rsp_ready = 1'b1;
      tick();
      b_req_valid = 1'b0; b_req_wdata = '0;
      check_i("l1_not_early", int'(b_rsp_valid), 0);
      tick();
      check_i("l1_valid", int'(b_rsp_valid), 1);
      check("l1_rdata", b_rsp_rdata, (i == 0) ? 128'h0 : 128'h7777_0000_7777_1111_7777_2222_7777_3333);
      tick();
      check_i("l1_done", int'(b_rsp_valid), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
